// File: rtl/uop_slot_queue_pkg.sv
// Shared defines for the micro-op slot queue: slot geometry, branch-tag width
// and the slot layout used by both the queue top and its storage array.
package uop_slot_queue_pkg;

    localparam int SLOT_WIDTH             = 36;
    localparam int MAX_PREDICT_DEPTH_BITS = 2;

    localparam int INSTR_MSB = 35;
    localparam int INSTR_LSB = 4;
    localparam int TAG_MSB   = 3;
    localparam int TAG_LSB   = 2;
    localparam int SPEC_BIT  = 1;
    localparam int VALID_BIT = 0;

    typedef struct packed {
        logic [INSTR_MSB-INSTR_LSB:0]       instr;
        logic [MAX_PREDICT_DEPTH_BITS-1:0]  tag;
        logic                               spec;
        logic                               valid;
    } slot_t;

    // A slot is killed when it is speculative and sits under the squashed branch tag.
    function automatic logic squash_hit(
        input slot_t                             s,
        input logic                              sq_valid,
        input logic [MAX_PREDICT_DEPTH_BITS-1:0] sq_tag
    );
        return sq_valid & s.spec & (s.tag == sq_tag);
    endfunction

endpackage

// File: rtl/uop_slot_mem.sv
// DEPTH-entry slot store with a live bit per entry: two write ports, one
// combinational read port, and a broadcast squash that clears matching live bits.
module uop_slot_mem
    import uop_slot_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr0_en,
    input  logic [AW-1:0]                     wr0_addr,
    input  slot_t                             wr0_slot,
    input  logic                              wr0_live,
    input  logic                              wr1_en,
    input  logic [AW-1:0]                     wr1_addr,
    input  slot_t                             wr1_slot,
    input  logic                              wr1_live,
    input  logic                              kill_en,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] kill_tag,
    input  logic [AW-1:0]                     rd_addr,
    output slot_t                             rd_slot,
    output logic                              rd_live
);

    slot_t            mem_r [DEPTH];
    logic [DEPTH-1:0] live_r;

    assign rd_slot = mem_r[rd_addr];
    assign rd_live = live_r[rd_addr];

    // Entry update: a fresh write wins over a squash of whatever the entry held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            live_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr0_en && (wr0_addr == AW'(i))) begin
                    mem_r[i]  <= wr0_slot;
                    live_r[i] <= wr0_live;
                end else if (wr1_en && (wr1_addr == AW'(i))) begin
                    mem_r[i]  <= wr1_slot;
                    live_r[i] <= wr1_live;
                end else if (squash_hit(mem_r[i], kill_en, kill_tag)) begin
                    live_r[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/uop_slot_queue.sv
// Two-slot-in, one-slot-out micro-op queue with branch squash and flush.
// Dead (squashed) entries drain from the head silently, one per cycle.
module uop_slot_queue
    import uop_slot_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SLOT_WIDTH = uop_slot_queue_pkg::SLOT_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2*SLOT_WIDTH-1:0]           in_bundle,
    input  logic                              squash_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] squash_tag,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SLOT_WIDTH-1:0]             out_slot,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] free_s;
    slot_t         slot0_s;
    slot_t         slot1_s;
    slot_t         first_s;
    slot_t         head_slot_s;
    logic          head_live_s;
    logic          accept_s;
    logic          pop_s;
    logic [1:0]    push_n_s;
    logic          wr0_en_s;
    logic          wr1_en_s;
    logic          wr0_live_s;
    logic          wr1_live_s;

    assign slot0_s = slot_t'(in_bundle[2*SLOT_WIDTH-1:SLOT_WIDTH]);
    assign slot1_s = slot_t'(in_bundle[SLOT_WIDTH-1:0]);
    assign count   = count_r;

    // Handshake, push/pop decisions and head presentation.
    always_comb begin
        free_s     = CW'(DEPTH) - count_r;
        in_ready   = (free_s >= CW'(2)) && !flush;
        accept_s   = in_valid && in_ready;
        push_n_s   = accept_s ? ({1'b0, slot0_s.valid} + {1'b0, slot1_s.valid}) : 2'd0;
        first_s    = slot0_s.valid ? slot0_s : slot1_s;
        wr0_en_s   = (push_n_s != 2'd0);
        wr1_en_s   = (push_n_s == 2'd2);
        // Slots arriving under an active squash are stored already dead.
        wr0_live_s = !squash_hit(first_s, squash_valid, squash_tag);
        wr1_live_s = !squash_hit(slot1_s, squash_valid, squash_tag);
        out_valid  = (count_r != CW'(0)) && head_live_s;
        pop_s      = (count_r != CW'(0)) && (!head_live_s || out_ready);
        out_slot   = (count_r != CW'(0)) ? SLOT_WIDTH'(head_slot_s) : {SLOT_WIDTH{1'b0}};
    end

    // Pointer and occupancy bookkeeping; flush overrides everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push_n_s);
            rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            count_r  <= count_r + CW'(push_n_s) - CW'(pop_s);
        end
    end

    uop_slot_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .rst_n    (reset),
        .wr0_en   (wr0_en_s),
        .wr0_addr (wr_ptr_r),
        .wr0_slot (first_s),
        .wr0_live (wr0_live_s),
        .wr1_en   (wr1_en_s),
        .wr1_addr (wr_ptr_r + AW'(1)),
        .wr1_slot (slot1_s),
        .wr1_live (wr1_live_s),
        .kill_en  (squash_valid && !flush),
        .kill_tag (squash_tag),
        .rd_addr  (rd_ptr_r),
        .rd_slot  (head_slot_s),
        .rd_live  (head_live_s)
    );

endmodule

// File: tb/tb_uop_slot_queue.sv
// Bench for uop_slot_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uop_slot_queue;

    localparam int DEPTH = 8;
    localparam int SW    = 36;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [71:0]   in_bundle;
    logic          squash_valid;
    logic [1:0]    squash_tag;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_slot;
    logic [3:0]    count;

    int total = 0;
    int bad   = 0;

    logic [SW-1:0] mq_slot[$];
    bit            mq_live[$];

    uop_slot_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bundle    (in_bundle),
        .squash_valid (squash_valid),
        .squash_tag   (squash_tag),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_slot     (out_slot),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] mk(input logic [31:0] instr, input logic [1:0] tag,
                                       input logic sp, input logic v);
        return {instr, tag, sp, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs the queue must show given the model contents and the current inputs.
    task automatic model_compare();
        int n;
        n = mq_slot.size();
        chk("count", 64'(count), 64'(n));
        chk("out_valid", 64'(out_valid), 64'((n > 0) && mq_live[0]));
        chk("out_slot", 64'(out_slot), (n > 0) ? 64'(mq_slot[0]) : 64'd0);
        chk("in_ready", 64'(in_ready), 64'(((DEPTH - n) >= 2) && !flush));
    endtask

    // Advance the model across one clock edge.
    task automatic model_step();
        int            n;
        bit            rdy;
        bit            pop;
        logic [35:0]   s;
        n   = mq_slot.size();
        rdy = ((DEPTH - n) >= 2) && !flush;
        if (flush) begin
            mq_slot.delete();
            mq_live.delete();
        end else begin
            pop = (n > 0) && (!mq_live[0] || out_ready);
            if (squash_valid) begin
                foreach (mq_slot[i]) begin
                    if (mq_slot[i][1] && (mq_slot[i][3:2] == squash_tag)) mq_live[i] = 1'b0;
                end
            end
            if (pop) begin
                void'(mq_slot.pop_front());
                void'(mq_live.pop_front());
            end
            if (in_valid && rdy) begin
                for (int k = 0; k < 2; k++) begin
                    s = (k == 0) ? in_bundle[71:36] : in_bundle[35:0];
                    if (s[0]) begin
                        mq_slot.push_back(s);
                        mq_live.push_back(!(squash_valid && s[1] && (s[3:2] == squash_tag)));
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic iv, input logic [71:0] b, input logic sq,
                         input logic [1:0] st, input logic fl, input logic ordy);
        @(negedge clk);
        in_valid     = iv;
        in_bundle    = b;
        squash_valid = sq;
        squash_tag   = st;
        flush        = fl;
        out_ready    = ordy;
        #1;
        model_compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; (i < 40) && (mq_slot.size() > 0); i++) cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("drain_empty", 64'(count), 64'd0);
    endtask

    task automatic fill_full();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, {mk(32'(i + 16), 2'd0, 1'b0, 1'b1), mk(32'(i + 32), 2'd3, 1'b1, 1'b1)},
                  1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    localparam logic [35:0] S35 = 36'h012050217;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_bundle = '0; squash_valid = 1'b0;
        squash_tag = '0; flush = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_slot", 64'(out_slot), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #10 reset = 1'b1;

        // Two valid slots, consumer ready: same slot value on two consecutive cycles.
        cycle(1'b1, {S35, S35}, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p035_count", 64'(count), 64'd2);
        chk("p035_valid0", 64'(out_valid), 64'd1);
        chk("p035_slot0", 64'(out_slot), 64'(S35));
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p035_slot1", 64'(out_slot), 64'(S35));
        chk("p035_count1", 64'(count), 64'd1);
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p035_empty", 64'(count), 64'd0);
        chk("p035_zero_slot", 64'(out_slot), 64'd0);

        // Slot 1 invalid: one push only.
        cycle(1'b1, {mk(32'hAAAA, 2'd0, 1'b0, 1'b1), 36'd0}, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("p036_count", 64'(count), 64'd1);
        chk("p036_slot", 64'(out_slot), 64'(mk(32'hAAAA, 2'd0, 1'b0, 1'b1)));
        drain();

        // Backpressure: full at 8, ready returns once two entries free.
        fill_full();
        chk("p037_full", 64'(count), 64'd8);
        chk("p037_rdy_full", 64'(in_ready), 64'd0);
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p037_rdy_7", 64'(in_ready), 64'd0);
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p037_count6", 64'(count), 64'd6);
        chk("p037_rdy_6", 64'(in_ready), 64'd1);
        drain();

        // Squash tag 2 among tags 2,1,2: only the tag-1 slot is presented.
        cycle(1'b1, {mk(32'h1, 2'd2, 1'b1, 1'b1), mk(32'h2, 2'd1, 1'b1, 1'b1)}, 1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, {mk(32'h3, 2'd2, 1'b1, 1'b1), 36'd0}, 1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b0, 72'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        chk("p038_count3", 64'(count), 64'd3);
        chk("p038_dead_head", 64'(out_valid), 64'd0);
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p038_live", 64'(out_valid), 64'd1);
        chk("p038_slot", 64'(out_slot), 64'(mk(32'h2, 2'd1, 1'b1, 1'b1)));
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p038_after", 64'(out_valid), 64'd0);
        cycle(1'b0, 72'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("p038_count0", 64'(count), 64'd0);

        // Flush with a full queue and a bundle offered.
        fill_full();
        cycle(1'b1, {S35, S35}, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("p039_count", 64'(count), 64'd0);
        chk("p039_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges with five entries held.
        cycle(1'b1, {mk(32'h51, 2'd0, 1'b0, 1'b1), mk(32'h52, 2'd0, 1'b0, 1'b1)}, 1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, {mk(32'h53, 2'd0, 1'b0, 1'b1), mk(32'h54, 2'd0, 1'b0, 1'b1)}, 1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, {mk(32'h55, 2'd0, 1'b0, 1'b1), 36'd0}, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("p040_count5", 64'(count), 64'd5);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("p040_rst_count", 64'(count), 64'd0);
        chk("p040_rst_valid", 64'(out_valid), 64'd0);
        chk("p040_rst_slot", 64'(out_slot), 64'd0);
        mq_slot.delete();
        mq_live.delete();
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++)
            cycle(i[0] == 1'b0, {mk(32'(100 + 2 * i), 2'(i), 1'b0, 1'b1), mk(32'(101 + 2 * i), 2'(i), 1'b0, 1'b1)},
                  1'b0, 2'd0, 1'b0, 1'b1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [71:0] b;
            b = {mk($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0),
                 mk($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0)};
            cycle($urandom_range(0, 9) < 7, b, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
